rf_dump_port: RTL
=================

# rf_dump_port

Hardware register-file dump engine for the MIPS core. On a `start` pulse it walks every architectural register through a dedicated read port on the register file. It streams each `{index, value}` pair out over a valid/ready interface, so a bench monitor, UART bridge or debug host can consume the final machine state without reaching into the hierarchy. It sits beside `rf` as the reader-side end of the register file: the core writes registers, this block reads them out.

## Interface
- `NREGS`, 32, number of registers dumped (indices 0..NREGS-1)
- `DATA_W`, 32, register width
- `IDX_W`, 5, index width; must satisfy 2^IDX_W >= NREGS
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request a dump; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is left
- `rf_raddr`  out  IDX_W  read address into the register file's debug read port
- `rf_rdata`  in  DATA_W  combinational read data for `rf_raddr` (same-cycle, matching `rf` async read)
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  consumer accepts the beat when `out_valid && out_ready` at a rising edge
- `out_idx`  out  IDX_W  register index of the current beat
- `out_data`  out  DATA_W  captured register value of the current beat
- `done`  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE: `start`=1 -> FETCH with idx=0. Otherwise stay in IDLE.
- FETCH: drive `rf_raddr`=idx. At the edge, capture `rf_rdata` into `out_data` and idx into `out_idx`, then -> SEND.
- SEND: `out_valid`=1. On a handshake:
  - if idx==NREGS-1 -> DONE;
  - else idx+1 -> FETCH.
- Without a handshake, hold every output.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `out_data` and `out_idx` are snapshots. They must not change during a stall, even if `rf_rdata` changes.
- Freezing the core during a dump is the system's job. Each value reflects the register at its own FETCH cycle.
- `start` is ignored outside IDLE. No queueing.
- Holding `start` high continuously restarts a dump on the cycle after DONE.
- `rf_raddr` outside FETCH: holds the last idx (0 after reset). It has no side effects.
- idx counter: IDX_W bits. It never exceeds NREGS-1 and never wraps.
- Reset (any state, any time, asynchronous) -> IDLE. All outputs return to 0 immediately: `busy`, `out_valid`, `done`, `out_idx`, `out_data`, `rf_raddr`. A partial dump is abandoned; no `done` is produced.

## Timing
- Let `start` be sampled at edge 0. Then:
  - FETCH runs in cycle 1;
  - `out_valid` rises after edge 1;
  - `busy` is high from after edge 0.
- With `out_ready` tied high, each register costs 2 cycles (FETCH + SEND).
- For NREGS=32, the last handshake is at edge 64 and `done` is high in cycle 65.
- `busy` falls after edge 65, coincident with the return to IDLE.
- `out_valid` must not depend combinationally on `out_ready`. All outputs are registered or decoded from state only.

## Structure
- Shared package: the state enum (IDLE/FETCH/SEND/DONE) and the default NREGS/DATA_W/IDX_W constants, reused by `rf` and the bench monitor.
- No sub-module: FSM, idx counter and capture register fit in one module.
- `rf` gains a second async read port driven by `rf_raddr`.

## Test plan
- Reset: hold `reset`=1 with `start`=1 -> all outputs 0 and state stays IDLE. Deassert mid-cycle -> no dump starts until `start` is sampled.
- Full dump: stub regfile returns `i*32'h01010101`, `out_ready`=1, pulse `start` -> 32 beats with idx 0..31 and data 0x00000000..0x1F1F1F1F, `done` in cycle 65, `busy` low at cycle 66.
- Backpressure: drop `out_ready` for 3 cycles on beat 5 -> `out_valid`, `out_idx`=5 and `out_data`=0x05050505 held. No beat is skipped or duplicated.
- Snapshot: while beat 7 is stalled, the stub changes reg 7 to 0xDEADBEEF -> `out_data` stays 0x07070707.
- Start handling: pulse `start` at beat 10 -> ignored, still 32 beats total. Hold `start` high throughout -> a second dump begins at idx 0 in the cycle after `done`.
- Mid-dump reset: assert `reset` asynchronously between edges during beat 12 -> outputs 0 without waiting for an edge, no `done`. A subsequent `start` produces a clean 32-beat dump from idx 0.

Source files
------------

// File: rtl/rf_dump_port_pkg.sv
// Shared definitions for the register-file dump engine: FSM states and
// default geometry of the architectural register file.
package rf_dump_port_pkg;

  localparam int RF_NREGS  = 32;
  localparam int RF_DATA_W = 32;
  localparam int RF_IDX_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/rf_dump_port.sv
// Walks every register through the rf debug read port and streams
// {index, value} snapshots over a valid/ready interface.
module rf_dump_port
  import rf_dump_port_pkg::*;
#(
  parameter int NREGS  = RF_NREGS,
  parameter int DATA_W = RF_DATA_W,
  parameter int IDX_W  = RF_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
        end
      end
      ST_FETCH: begin
        // Snapshot here so a stalled beat is immune to later register writes.
        out_data_d = rf_rdata;
        out_idx_d  = idx_q;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only; no path from out_ready.
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_SEND);
  assign done      = (state_q == ST_DONE);
  assign rf_raddr  = idx_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;

endmodule
